// File: rtl/aesl_deadlock_axis_watchdog_if.sv
// Probe/report bundle of the kernel deadlock watchdog.
// master drives the probes, slave is the watchdog itself.
interface aesl_deadlock_axis_watchdog_if #(
  parameter int NUM_AXIS = 2,
  parameter int NUM_INST = 3,
  parameter int CNT_W    = 16
);
  logic [NUM_AXIS-1:0] axis_block_sigs;
  logic [NUM_INST-1:0] inst_idle_sigs;
  logic [NUM_INST-1:0] inst_block_sigs;
  logic                rearm;
  logic                kernel_block;
  logic                deadlock;
  logic                rpt_valid;
  logic [NUM_AXIS-1:0] rpt_dst;
  logic [NUM_AXIS-1:0] rpt_src;
  logic [NUM_INST-1:0] rpt_inst;
  logic [CNT_W-1:0]    block_cycles;
  logic [7:0]          event_count;

  modport master (
    output axis_block_sigs, inst_idle_sigs,
    output inst_block_sigs, rearm,
    input  kernel_block, deadlock, rpt_valid,
    input  rpt_dst, rpt_src, rpt_inst,
    input  block_cycles, event_count
  );

  modport slave (
    input  axis_block_sigs, inst_idle_sigs,
    input  inst_block_sigs, rearm,
    output kernel_block, deadlock, rpt_valid,
    output rpt_dst, rpt_src, rpt_inst,
    output block_cycles, event_count
  );
endinterface

// File: rtl/aesl_deadlock_axis_watchdog.sv
// Deadlock watchdog for HLS co-simulation: qualifies a
// sustained block, snapshots the blocked ports, reports.
module aesl_deadlock_axis_watchdog #(
  parameter int NUM_AXIS      = 2,
  parameter int NUM_INST      = 3,
  parameter int BLOCK_THRESH  = 2,
  parameter int SETTLE_CYCLES = 10,
  parameter int ONE_SHOT      = 1,
  parameter int CNT_W         = 16
) (
  input  logic kernel_monitor_clock,
  input  logic kernel_monitor_reset,
  aesl_deadlock_axis_watchdog_if.slave bus
);
  localparam logic [2:0] S_SETTLE = 3'd0;
  localparam logic [2:0] S_IDLE   = 3'd1;
  localparam logic [2:0] S_QUAL   = 3'd2;
  localparam logic [2:0] S_CDST   = 3'd3;
  localparam logic [2:0] S_CSRC   = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;
  localparam logic [2:0] S_HOLD   = 3'd6;

  localparam int SW =
    (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int RW = $clog2(BLOCK_THRESH + 1);
  localparam logic [SW-1:0] SETTLE_LAST =
    SW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
  localparam logic [RW-1:0] RUN_THR = RW'(BLOCK_THRESH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic                w_raw;
  logic                w_enter_done;
  logic                w_settle_done;
  logic [2:0]          w_next;
  logic [SW-1:0]       w_settle_nx;
  logic [RW-1:0]       w_run_nx;

  logic [2:0]          r_state;
  logic [SW-1:0]       r_settle;
  logic [RW-1:0]       r_run;
  logic                r_armed;
  logic                r_kblk;
  logic                r_dl;
  logic [7:0]          r_evt;
  logic [CNT_W-1:0]    r_bcnt;
  logic [NUM_AXIS-1:0] r_dst;
  logic [NUM_AXIS-1:0] r_src;
  logic [NUM_INST-1:0] r_inst;

  assign w_raw = (|bus.axis_block_sigs) |
                 (|bus.inst_block_sigs);
  assign w_enter_done = (r_state == S_CSRC);
  assign w_settle_done = (SETTLE_CYCLES == 0) ||
                         (r_settle == SETTLE_LAST);

  always_comb begin
    w_next      = r_state;
    w_settle_nx = r_settle;
    w_run_nx    = r_run;
    unique case (r_state)
      S_SETTLE: begin
        if (w_settle_done) w_next = S_IDLE;
        else w_settle_nx = r_settle + SW'(1);
      end
      S_IDLE: begin
        if (w_raw && r_armed) begin
          w_next   = S_QUAL;
          w_run_nx = RW'(1);
        end
      end
      S_QUAL: begin
        if (!w_raw) begin
          w_next   = S_IDLE;
          w_run_nx = '0;
        end else if (r_run == RUN_THR) begin
          w_next = S_CDST;
        end else begin
          w_run_nx = r_run + RW'(1);
        end
      end
      S_CDST: w_next = S_CSRC;
      S_CSRC: w_next = S_DONE;
      S_DONE: w_next = (ONE_SHOT != 0) ? S_HOLD : S_IDLE;
      S_HOLD: if (bus.rearm) w_next = S_IDLE;
      default: w_next = S_SETTLE;
    endcase
  end

  always_ff @(posedge kernel_monitor_clock) begin
    if (kernel_monitor_reset) begin
      r_state  <= S_SETTLE;
      r_settle <= '0;
      r_run    <= '0;
      r_armed  <= 1'b1;
      r_kblk   <= 1'b0;
      r_dl     <= 1'b0;
      r_evt    <= '0;
      r_bcnt   <= '0;
      r_dst    <= '0;
      r_src    <= '0;
      r_inst   <= '0;
    end else begin
      r_state  <= w_next;
      r_settle <= w_settle_nx;
      r_run    <= w_run_nx;
      r_kblk   <= w_raw;
      if (!w_raw) r_bcnt <= '0;
      else if (r_bcnt != CNT_MAX) r_bcnt <= r_bcnt + 1'b1;
      // one report per episode: re-arm only after a clean sample
      if (ONE_SHOT != 0) r_armed <= 1'b1;
      else if (w_enter_done) r_armed <= 1'b0;
      else if (!w_raw) r_armed <= 1'b1;
      if (bus.rearm) r_dl <= 1'b0;
      else if (w_enter_done) r_dl <= 1'b1;
      if (w_enter_done && r_evt != 8'hFF)
        r_evt <= r_evt + 8'd1;
      if (r_state == S_CDST)
        r_dst <= ~bus.axis_block_sigs;
      if (r_state == S_CSRC) begin
        r_src  <= bus.axis_block_sigs;
        r_inst <= bus.inst_block_sigs &
                  ~bus.inst_idle_sigs;
      end
    end
  end

  assign bus.kernel_block = r_kblk;
  assign bus.deadlock     = r_dl;
  assign bus.rpt_valid    = (r_state == S_DONE);
  assign bus.rpt_dst      = r_dst;
  assign bus.rpt_src      = r_src;
  assign bus.rpt_inst     = r_inst;
  assign bus.block_cycles = r_bcnt;
  assign bus.event_count  = r_evt;
endmodule

// File: tb/tb_aesl_deadlock_axis_watchdog.sv
// Bench for the deadlock watchdog: four parameter sets,
// report scoreboard plus a vector table for the block counter.
module tb_aesl_deadlock_axis_watchdog;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic rst_a = 1'b1;
  logic rst_c = 1'b1;
  logic rst_d = 1'b1;
  logic rst_e = 1'b1;

  aesl_deadlock_axis_watchdog_if #(2, 3, 16) ia ();
  aesl_deadlock_axis_watchdog_if #(2, 3, 16) ic ();
  aesl_deadlock_axis_watchdog_if #(2, 3, 16) id ();
  aesl_deadlock_axis_watchdog_if #(2, 3, 4)  ie ();

  aesl_deadlock_axis_watchdog u_a (
    .kernel_monitor_clock(clk),
    .kernel_monitor_reset(rst_a),
    .bus(ia)
  );
  aesl_deadlock_axis_watchdog #(.BLOCK_THRESH(3)) u_c (
    .kernel_monitor_clock(clk),
    .kernel_monitor_reset(rst_c),
    .bus(ic)
  );
  aesl_deadlock_axis_watchdog #(.ONE_SHOT(0)) u_d (
    .kernel_monitor_clock(clk),
    .kernel_monitor_reset(rst_d),
    .bus(id)
  );
  aesl_deadlock_axis_watchdog #(.CNT_W(4)) u_e (
    .kernel_monitor_clock(clk),
    .kernel_monitor_reset(rst_e),
    .bus(ie)
  );

  typedef struct {
    int         id;
    int         cyc;
    logic [1:0] dst;
    logic [1:0] src;
    logic [2:0] inst;
    logic [7:0] ev;
    logic       dl;
  } rpt_t;

  typedef struct {
    logic [1:0] axis;
    logic [2:0] iblk;
    logic       kb;
    int         bc;
  } vec_t;

  rpt_t sb[$];
  vec_t tv[8];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)",
               nm, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic exp_rpt(input int dut, input int dly,
                         input logic [1:0] dst,
                         input logic [1:0] src,
                         input logic [2:0] inst,
                         input logic [7:0] ev,
                         input logic dl);
    rpt_t e;
    e.id = dut; e.cyc = cyc + dly;
    e.dst = dst; e.src = src; e.inst = inst;
    e.ev = ev; e.dl = dl;
    sb.push_back(e);
  endtask

  task automatic mon(input int dut,
                     input logic [1:0] dst,
                     input logic [1:0] src,
                     input logic [2:0] inst,
                     input logic [7:0] ev,
                     input logic dl);
    rpt_t e;
    if (sb.size() == 0 || sb[0].id != dut) begin
      total++;
      bad++;
      $display("FAIL unexpected_rpt: dut %0d at cyc %0d",
               dut, cyc);
      return;
    end
    e = sb.pop_front();
    chk("rpt_cycle", cyc, e.cyc);
    chk("rpt_dst", dst, e.dst);
    chk("rpt_src", src, e.src);
    chk("rpt_inst", inst, e.inst);
    chk("rpt_event_count", ev, e.ev);
    chk("rpt_deadlock", dl, e.dl);
  endtask

  always @(negedge clk) begin
    if (ia.rpt_valid)
      mon(0, ia.rpt_dst, ia.rpt_src, ia.rpt_inst,
          ia.event_count, ia.deadlock);
    if (ic.rpt_valid)
      mon(1, ic.rpt_dst, ic.rpt_src, ic.rpt_inst,
          ic.event_count, ic.deadlock);
    if (id.rpt_valid)
      mon(2, id.rpt_dst, id.rpt_src, id.rpt_inst,
          id.event_count, id.deadlock);
    if (ie.rpt_valid)
      mon(3, ie.rpt_dst, ie.rpt_src, ie.rpt_inst,
          ie.event_count, ie.deadlock);
  end

  task automatic chk_zero_a(input string tag);
    chk({tag, "_kernel_block"}, ia.kernel_block, 0);
    chk({tag, "_deadlock"}, ia.deadlock, 0);
    chk({tag, "_rpt_valid"}, ia.rpt_valid, 0);
    chk({tag, "_event_count"}, ia.event_count, 0);
    chk({tag, "_block_cycles"}, ia.block_cycles, 0);
    chk({tag, "_rpt_dst"}, ia.rpt_dst, 0);
    chk({tag, "_rpt_src"}, ia.rpt_src, 0);
    chk({tag, "_rpt_inst"}, ia.rpt_inst, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    tv[0] = '{2'b00, 3'b000, 1'b0, 0};
    tv[1] = '{2'b01, 3'b000, 1'b1, 1};
    tv[2] = '{2'b10, 3'b000, 1'b1, 2};
    tv[3] = '{2'b00, 3'b100, 1'b1, 3};
    tv[4] = '{2'b00, 3'b000, 1'b0, 0};
    tv[5] = '{2'b00, 3'b010, 1'b1, 1};
    tv[6] = '{2'b11, 3'b001, 1'b1, 2};
    tv[7] = '{2'b00, 3'b000, 1'b0, 0};

    ia.axis_block_sigs = '0; ia.inst_idle_sigs = '0;
    ia.inst_block_sigs = '0; ia.rearm = 1'b0;
    ic.axis_block_sigs = '0; ic.inst_idle_sigs = '0;
    ic.inst_block_sigs = '0; ic.rearm = 1'b0;
    id.axis_block_sigs = '0; id.inst_idle_sigs = '0;
    id.inst_block_sigs = '0; id.rearm = 1'b0;
    ie.axis_block_sigs = '0; ie.inst_idle_sigs = '0;
    ie.inst_block_sigs = '0; ie.rearm = 1'b0;

    // one-shot report, then hold
    step(3);
    chk_zero_a("reset");
    rst_a = 1'b0;
    step(17);
    ia.axis_block_sigs = 2'b01;
    exp_rpt(0, 5, 2'b10, 2'b01, 3'b000, 8'd1, 1'b1);
    step(8);
    chk("run_block_cycles", ia.block_cycles, 8);
    chk("run_kernel_block", ia.kernel_block, 1);
    chk("hold_deadlock", ia.deadlock, 1);
    ia.axis_block_sigs = 2'b00;
    step(1);
    for (int i = 0; i < 8; i++) begin
      ia.axis_block_sigs = tv[i].axis;
      ia.inst_block_sigs = tv[i].iblk;
      step(1);
      chk("vec_kernel_block", ia.kernel_block, tv[i].kb);
      chk("vec_block_cycles", ia.block_cycles, tv[i].bc);
    end
    chk("hold_deadlock_after_vec", ia.deadlock, 1);

    // rearm releases HOLD; block still present re-reports
    ia.axis_block_sigs = 2'b01;
    ia.inst_block_sigs = 3'b101;
    ia.inst_idle_sigs  = 3'b001;
    ia.rearm = 1'b1;
    exp_rpt(0, 6, 2'b10, 2'b01, 3'b100, 8'd2, 1'b1);
    step(1);
    ia.rearm = 1'b0;
    chk("rearm_clears_deadlock", ia.deadlock, 0);
    step(8);
    ia.axis_block_sigs = '0;
    ia.inst_block_sigs = '0;
    ia.inst_idle_sigs  = '0;
    step(2);

    // block only inside the settle window
    rst_a = 1'b1;
    step(1);
    rst_a = 1'b0;
    step(1);
    ia.axis_block_sigs = 2'b10;
    step(7);
    chk("settle_bc_peak", ia.block_cycles, 7);
    ia.axis_block_sigs = 2'b00;
    step(1);
    chk("settle_bc_cleared", ia.block_cycles, 0);
    step(20);
    chk("settle_deadlock", ia.deadlock, 0);
    chk("settle_event_count", ia.event_count, 0);

    // block present as settle ends
    rst_a = 1'b1;
    step(1);
    rst_a = 1'b0;
    ia.axis_block_sigs = 2'b11;
    exp_rpt(0, 15, 2'b00, 2'b11, 3'b000, 8'd1, 1'b1);
    step(20);

    // reset during COLLECT_SRC aborts capture
    ia.axis_block_sigs = 2'b00;
    ia.rearm = 1'b1;
    step(1);
    ia.rearm = 1'b0;
    step(3);
    ia.axis_block_sigs = 2'b01;
    step(4);
    rst_a = 1'b1;
    step(1);
    chk_zero_a("midcap");
    rst_a = 1'b0;
    exp_rpt(0, 15, 2'b10, 2'b01, 3'b000, 8'd1, 1'b1);
    step(20);
    ia.axis_block_sigs = 2'b00;
    step(2);

    // threshold 3 glitch
    rst_c = 1'b0;
    step(15);
    ic.axis_block_sigs = 2'b01;
    step(3);
    ic.axis_block_sigs = 2'b00;
    step(1);
    ic.axis_block_sigs = 2'b01;
    exp_rpt(1, 6, 2'b10, 2'b01, 3'b000, 8'd1, 1'b1);
    step(10);

    // rearm coincident with DONE entry
    ic.axis_block_sigs = 2'b00;
    ic.rearm = 1'b1;
    step(1);
    ic.rearm = 1'b0;
    step(3);
    chk("c_rearm_deadlock", ic.deadlock, 0);
    ic.axis_block_sigs = 2'b01;
    exp_rpt(1, 6, 2'b10, 2'b01, 3'b000, 8'd2, 1'b0);
    step(5);
    ic.rearm = 1'b1;
    step(1);
    ic.rearm = 1'b0;
    chk("rearm_vs_done_deadlock", ic.deadlock, 0);
    step(5);
    chk("rearm_vs_done_later", ic.deadlock, 0);
    chk("rearm_vs_done_events", ic.event_count, 2);
    ic.axis_block_sigs = 2'b00;

    // continuous mode: two episodes, then one long block
    rst_d = 1'b0;
    step(15);
    id.axis_block_sigs = 2'b10;
    exp_rpt(2, 5, 2'b01, 2'b10, 3'b000, 8'd1, 1'b1);
    step(8);
    id.axis_block_sigs = 2'b00;
    step(1);
    id.axis_block_sigs = 2'b10;
    exp_rpt(2, 5, 2'b01, 2'b10, 3'b000, 8'd2, 1'b1);
    step(25);
    id.axis_block_sigs = 2'b00;
    step(2);
    chk("cont_event_count", id.event_count, 2);
    chk("cont_deadlock", id.deadlock, 1);

    // saturating 4-bit block counter
    rst_e = 1'b0;
    ie.axis_block_sigs = 2'b01;
    exp_rpt(3, 15, 2'b10, 2'b01, 3'b000, 8'd1, 1'b1);
    step(14);
    chk("sat_bc_14", ie.block_cycles, 14);
    step(1);
    chk("sat_bc_15", ie.block_cycles, 15);
    step(5);
    chk("sat_bc_hold", ie.block_cycles, 15);
    ie.axis_block_sigs = 2'b00;
    step(1);
    chk("sat_bc_clear", ie.block_cycles, 0);
    step(2);

    while (sb.size() > 0) begin
      total++;
      bad++;
      $display("FAIL missing_rpt: dut %0d expected at cyc %0d",
               sb[0].id, sb[0].cyc);
      void'(sb.pop_front());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
